// File: rtl/traffic_pkg.sv
// ----------------------------------------------------------------------------
// traffic_pkg
//   Encodings shared by the traffic-control blocks.
//   - lamp_t  : lamp drive code (RED=00, YELLOW=01, GREEN=10)
//   - state_t : phase scheduler state code, also exported for debug
//   - phase_t : which vehicle approach owns GREEN/YELLOW (NS=0, EW=1)
//   - lamp_for(): lamp code an approach shows for a given state/served phase
// ----------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    LAMP_RED    = 2'b00,
    LAMP_YELLOW = 2'b01,
    LAMP_GREEN  = 2'b10
  } lamp_t;

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_GREEN   = 3'd1,
    ST_YELLOW  = 3'd2,
    ST_WALK    = 3'd3,
    ST_PREEMPT = 3'd4
  } state_t;

  typedef enum logic {
    PH_NS = 1'b0,
    PH_EW = 1'b1
  } phase_t;

  // Only the served approach can ever leave RED, which is what keeps the
  // two vehicle lamps from showing conflicting GREEN/YELLOW together.
  function automatic lamp_t lamp_for(state_t st, phase_t served, phase_t approach);
    lamp_t lamp;
    lamp = LAMP_RED;
    if (served == approach) begin
      case (st)
        ST_GREEN:  lamp = LAMP_GREEN;
        ST_YELLOW: lamp = LAMP_YELLOW;
        default:   lamp = LAMP_RED;
      endcase
    end
    return lamp;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// ----------------------------------------------------------------------------
// phase_timer
//   Up-counter that restarts on clr and saturates at limit.
//   Ports:
//     clk, rst_n : clock / asynchronous active-low reset
//     clr        : restart at 0 on this edge (state entry)
//     limit      : saturation value, also the compare value for `at`
//     count      : current count
//     at         : count == limit
// ----------------------------------------------------------------------------
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             at
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (count_q != limit) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign at    = (count_q == limit);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// ----------------------------------------------------------------------------
// traffic_phase_scheduler
//   Actuated scheduler for a two-approach intersection with a pedestrian
//   walk phase and emergency preemption. Enforces min/max green, yellow and
//   all-red clearance, and drives the lamps from registers.
//   Ports:
//     clk, rst_n       : clock / asynchronous active-low reset
//     ns_req, ew_req   : vehicle detectors (level)
//     ped_req          : pedestrian button (pulse, latched)
//     emergency        : preemption request (level)
//     ns_light,ew_light: lamp codes (RED=00, YELLOW=01, GREEN=10)
//     ped_walk         : walk lamp
//     sched_state      : current state code (debug)
// ----------------------------------------------------------------------------
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 5,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_req,
  input  logic       emergency,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       ped_walk,
  output logic [2:0] sched_state
);

  // Exit compare values: a state lasting N cycles leaves when count == N-1.
  localparam logic [CNT_W-1:0] LIM_MIN_G  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] LIM_MAX_G  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] LIM_YELLOW = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] LIM_ALLRED = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] LIM_WALK   = CNT_W'(WALK_T - 1);

  state_t state_q, state_d;
  phase_t phase_q, phase_d;
  logic   ns_pend_q, ns_pend_d;
  logic   ew_pend_q, ew_pend_d;
  logic   ped_pend_q, ped_pend_d;
  lamp_t  ns_light_q, ns_light_d;
  lamp_t  ew_light_q, ew_light_d;
  logic   ped_walk_q, ped_walk_d;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] limit;
  logic             at;
  logic             timer_clr;

  logic own_req;
  logic own_pend;
  logic opp_pend;
  logic conflict;
  logic gap_out;
  logic max_out;
  logic enter_green;
  logic enter_walk;

  // ---------------------------------------------------------------------------
  // Phase timer: restarted on every state entry. In PREEMPT the limit is 0 so
  // the counter simply parks there; the hold is governed by emergency alone.
  // ---------------------------------------------------------------------------
  always_comb begin
    limit = '0;
    case (state_q)
      ST_CLEAR:  limit = LIM_ALLRED;
      ST_GREEN:  limit = LIM_MAX_G;
      ST_YELLOW: limit = LIM_YELLOW;
      ST_WALK:   limit = LIM_WALK;
      default:   limit = '0;
    endcase
  end

  assign timer_clr = (state_d != state_q);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .limit (limit),
    .count (count),
    .at    (at)
  );

  // ---------------------------------------------------------------------------
  // Request qualification relative to the approach in phase_q. In CLEAR,
  // phase_q is the last served approach, so opp_pend is the "other side".
  // ---------------------------------------------------------------------------
  assign own_req  = (phase_q == PH_NS) ? ns_req    : ew_req;
  assign own_pend = (phase_q == PH_NS) ? ns_pend_q : ew_pend_q;
  assign opp_pend = (phase_q == PH_NS) ? ew_pend_q : ns_pend_q;
  assign conflict = opp_pend | ped_pend_q;

  // Gap-out waits for minimum green and a quiet own detector; max-out ignores
  // the detector once the green has run MAX_GREEN cycles against a conflict.
  // `at` only means "max reached" while in GREEN, hence both are gated there.
  assign gap_out = (count >= LIM_MIN_G) && conflict && !own_req;
  assign max_out = at && conflict;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      ST_CLEAR: begin
        if (at) begin
          if (emergency) begin
            state_d = ST_PREEMPT;
          end else if (ped_pend_q) begin
            state_d = ST_WALK;
          end else begin
            state_d = ST_GREEN;
            if (opp_pend) begin
              phase_d = (phase_q == PH_NS) ? PH_EW : PH_NS;
            end else if (own_pend) begin
              phase_d = phase_q;
            end else begin
              phase_d = PH_NS;  // rest phase
            end
          end
        end
      end
      ST_GREEN: begin
        if (emergency || gap_out || max_out) begin
          state_d = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        // Yellow always runs its full length, even under preemption.
        if (at) begin
          state_d = ST_CLEAR;
        end
      end
      ST_WALK: begin
        if (emergency || at) begin
          state_d = ST_CLEAR;
        end
      end
      ST_PREEMPT: begin
        if (!emergency) begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pending requests: a request arriving on the clearing edge keeps the bit set.
  // ---------------------------------------------------------------------------
  assign enter_green = (state_d == ST_GREEN) && (state_q != ST_GREEN);
  assign enter_walk  = (state_d == ST_WALK)  && (state_q != ST_WALK);

  always_comb begin
    ns_pend_d  = ns_req  | (ns_pend_q  & ~(enter_green && (phase_d == PH_NS)));
    ew_pend_d  = ew_req  | (ew_pend_q  & ~(enter_green && (phase_d == PH_EW)));
    ped_pend_d = ped_req | (ped_pend_q & ~enter_walk);
  end

  // ---------------------------------------------------------------------------
  // Lamp outputs are decoded from the next state and registered, so they move
  // on exactly the edge that enters a state.
  // ---------------------------------------------------------------------------
  always_comb begin
    ns_light_d = lamp_for(state_d, phase_d, PH_NS);
    ew_light_d = lamp_for(state_d, phase_d, PH_EW);
    ped_walk_d = (state_d == ST_WALK);
  end

  // Reset selects EW as last served so the first green after reset goes to NS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      phase_q    <= PH_EW;
      ns_pend_q  <= 1'b0;
      ew_pend_q  <= 1'b0;
      ped_pend_q <= 1'b0;
      ns_light_q <= LAMP_RED;
      ew_light_q <= LAMP_RED;
      ped_walk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      ns_pend_q  <= ns_pend_d;
      ew_pend_q  <= ew_pend_d;
      ped_pend_q <= ped_pend_d;
      ns_light_q <= ns_light_d;
      ew_light_q <= ew_light_d;
      ped_walk_q <= ped_walk_d;
    end
  end

  assign ns_light    = ns_light_q;
  assign ew_light    = ew_light_q;
  assign ped_walk    = ped_walk_q;
  assign sched_state = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// ----------------------------------------------------------------------------
// tb_traffic_phase_scheduler
//   Directed stimulus with a segment scoreboard. Each test pushes the expected
//   sequence of output segments {ns, ew, walk, state} with a length range in
//   cycles; a monitor samples outputs on the falling edge, closes a segment
//   whenever the output tuple changes (or reset asserts) and compares it with
//   the front of the queue.
// ----------------------------------------------------------------------------
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ns_req = 1'b0;
  logic       ew_req = 1'b0;
  logic       ped_req = 1'b0;
  logic       emergency = 1'b0;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       ped_walk;
  logic [2:0] sched_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected output tuples {ns[1:0], ew[1:0], walk, state[2:0]}
  localparam logic [7:0] T_CLR  = {2'b00, 2'b00, 1'b0, 3'd0};
  localparam logic [7:0] T_NSG  = {2'b10, 2'b00, 1'b0, 3'd1};
  localparam logic [7:0] T_NSY  = {2'b01, 2'b00, 1'b0, 3'd2};
  localparam logic [7:0] T_EWG  = {2'b00, 2'b10, 1'b0, 3'd1};
  localparam logic [7:0] T_EWY  = {2'b00, 2'b01, 1'b0, 3'd2};
  localparam logic [7:0] T_WALK = {2'b00, 2'b00, 1'b1, 3'd3};
  localparam logic [7:0] T_PRE  = {2'b00, 2'b00, 1'b0, 3'd4};

  typedef struct {
    string      name;
    logic [7:0] tup;
    int         lo;
    int         hi;
  } seg_t;

  seg_t exp_q[$];

  logic [7:0] mon_prev;
  logic [7:0] mon_cur;
  int         mon_run;

  always #5 clk = ~clk;

  traffic_phase_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ns_req      (ns_req),
    .ew_req      (ew_req),
    .ped_req     (ped_req),
    .emergency   (emergency),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .ped_walk    (ped_walk),
    .sched_state (sched_state)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(string name, int act, int lo, int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d cycles, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push(string name, logic [7:0] tup, int lo, int hi);
    seg_t s;
    s.name = name;
    s.tup  = tup;
    s.lo   = lo;
    s.hi   = hi;
    exp_q.push_back(s);
  endtask

  task automatic close_seg(logic [7:0] tup, int len);
    seg_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_seg: got tuple 0x%0h for %0d cycles, expected none", tup, len);
    end else begin
      e = exp_q.pop_front();
      check({e.name, "_out"}, 32'(tup), 32'(e.tup));
      check_range({e.name, "_len"}, len, e.lo, e.hi);
    end
  endtask

  // Monitor: segments are delimited by output changes and by reset.
  initial begin
    mon_run = 0;
    forever begin
      @(negedge clk);
      mon_cur = {ns_light, ew_light, ped_walk, sched_state};
      if (!rst_n) begin
        if (mon_run > 0) close_seg(mon_prev, mon_run);
        mon_run = 0;
      end else if (mon_run == 0) begin
        mon_prev = mon_cur;
        mon_run  = 1;
      end else if (mon_cur == mon_prev) begin
        mon_run++;
      end else begin
        close_seg(mon_prev, mon_run);
        mon_prev = mon_cur;
        mon_run  = 1;
      end
    end
  end

  // Inputs change 2 time units after the rising edge.
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_ns"},    32'(ns_light),    32'd0);
    check({tag, "_ew"},    32'(ew_light),    32'd0);
    check({tag, "_walk"},  32'(ped_walk),    32'd0);
    check({tag, "_state"}, 32'(sched_state), 32'd0);
  endtask

  // Asserts reset between edges, checks the outputs react at once, then
  // releases after 3 rising edges (release lands 2 units after an edge).
  task automatic do_reset(string tag);
    rst_n     = 1'b0;
    ns_req    = 1'b0;
    ew_req    = 1'b0;
    ped_req   = 1'b0;
    emergency = 1'b0;
    #1;
    check_reset_outputs(tag);
    cyc(3);
    check_reset_outputs({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, then rest in NS green with no requests.
    do_reset("t1_rst");
    push("t1_clear",   T_CLR, 2, 2);
    push("t1_ns_rest", T_NSG, 50, 60);
    cyc(57);

    // 2: gap-out from NS to EW, then 4: pedestrian request during EW green.
    do_reset("t2_rst");
    push("t2_clear0",  T_CLR, 2, 2);
    push("t2_ns_gap",  T_NSG, 4, 4);
    push("t2_ns_y",    T_NSY, 3, 3);
    push("t2_clear1",  T_CLR, 2, 2);
    push("t4_ew_gap",  T_EWG, 11, 11);
    push("t4_ew_y",    T_EWY, 3, 3);
    push("t4_clear0",  T_CLR, 2, 2);
    push("t4_walk",    T_WALK, 5, 5);
    push("t4_clear1",  T_CLR, 2, 2);
    push("t4_ns_rest", T_NSG, 5, 10);
    cyc(3);              // NS green count 1
    ew_req = 1'b1;
    cyc(1);
    ew_req = 1'b0;
    cyc(16);             // well into EW green rest
    ped_req = 1'b1;
    cyc(1);
    ped_req = 1'b0;
    cyc(20);

    // 3: max-out with both detectors held.
    do_reset("t3_rst");
    push("t3_clear0", T_CLR, 2, 2);
    push("t3_ns_max", T_NSG, 10, 10);
    push("t3_ns_y",   T_NSY, 3, 3);
    push("t3_clear1", T_CLR, 2, 2);
    push("t3_ew_max", T_EWG, 10, 10);
    push("t3_ew_y",   T_EWY, 3, 3);
    push("t3_clear2", T_CLR, 2, 2);
    push("t3_ns_max2", T_NSG, 10, 10);
    push("t3_ns_y2",  T_NSY, 3, 3);
    push("t3_clear3", T_CLR, 2, 2);
    push("t3_ew_cut", T_EWG, 1, 10);
    ns_req = 1'b1;
    ew_req = 1'b1;
    cyc(50);

    // 5: emergency preemption, then 6: asynchronous reset mid EW yellow.
    do_reset("t5_rst");
    push("t5_clear0",  T_CLR, 2, 2);
    push("t5_ns_pre",  T_NSG, 3, 3);
    push("t5_ns_y",    T_NSY, 3, 3);
    push("t5_clear1",  T_CLR, 2, 2);
    push("t5_preempt", T_PRE, 15, 15);
    push("t5_clear2",  T_CLR, 2, 2);
    push("t6_ns_gap",  T_NSG, 5, 5);
    push("t6_ns_y",    T_NSY, 3, 3);
    push("t6_clear0",  T_CLR, 2, 2);
    push("t6_ew_gap",  T_EWG, 5, 5);
    push("t6_ew_y_cut", T_EWY, 1, 3);
    push("t6_clear1",  T_CLR, 2, 2);
    push("t6_ns_rest", T_NSG, 10, 20);
    cyc(4);              // NS green count 2
    emergency = 1'b1;
    cyc(20);
    emergency = 1'b0;
    cyc(6);              // NS rest green
    ew_req = 1'b1;
    cyc(1);
    ew_req = 1'b0;
    cyc(9);              // EW green
    ns_req = 1'b1;
    cyc(1);
    ns_req = 1'b0;
    cyc(1);              // first EW yellow cycle: latch more requests
    ew_req  = 1'b1;
    ped_req = 1'b1;
    cyc(1);
    ew_req  = 1'b0;
    ped_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    check("t6_ns_pend",  32'(dut.ns_pend_q),  32'd0);
    check("t6_ew_pend",  32'(dut.ew_pend_q),  32'd0);
    check("t6_ped_pend", 32'(dut.ped_pend_q), 32'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(15);

    // Close the last open segment and make sure nothing expected is left.
    rst_n = 1'b0;
    cyc(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
